// File: rtl/pid_pkg.sv
// Shared definitions for the incremental PID term generator: default widths,
// sequencing states and clamp-limit helpers derived from the output width.
package pid_pkg;

  localparam int unsigned PID_ERR_W  = 12;
  localparam int unsigned PID_COEF_W = 8;
  localparam int unsigned PID_FRAC_W = 4;
  localparam int unsigned PID_DATA_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_P,
    ST_MUL_I,
    ST_MUL_D,
    ST_SAT
  } pid_state_e;

  function automatic longint pid_lim_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint pid_lim_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/pid_increment_if.sv
// Sample/result bus of the incremental PID term generator.
// The sat flag exists only when PID_INC_SAT_FLAG_EN is defined.
interface pid_increment_if
  import pid_pkg::*;
#(
  parameter int unsigned ERR_W  = PID_ERR_W,
  parameter int unsigned COEF_W = PID_COEF_W,
  parameter int unsigned DATA_W = PID_DATA_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ERR_W-1:0]  setpoint;
  logic signed [ERR_W-1:0]  feedback;
  logic        [COEF_W-1:0] kp;
  logic        [COEF_W-1:0] ki;
  logic        [COEF_W-1:0] kd;
  logic                     out_valid;
  logic signed [DATA_W-1:0] d_uk;
`ifdef PID_INC_SAT_FLAG_EN
  logic                     sat;
`endif

  modport master (
    output in_valid, setpoint, feedback, kp, ki, kd,
    input  in_ready, out_valid, d_uk
`ifdef PID_INC_SAT_FLAG_EN
    , input sat
`endif
  );

  modport slave (
    input  in_valid, setpoint, feedback, kp, ki, kd,
    output in_ready, out_valid, d_uk
`ifdef PID_INC_SAT_FLAG_EN
    , output sat
`endif
  );

endinterface

// File: rtl/pid_mac.sv
// Signed multiply-accumulate shared by the three gain terms; load restarts the sum.
module pid_mac #(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OP_W   = 15,
  parameter int unsigned ACC_W  = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [COEF_W-1:0]       coef,
  input  logic signed [OP_W-1:0]  operand,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [COEF_W:0]    coef_s;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_q;

  always_comb begin
    // gains are unsigned; a zero sign bit keeps the product fully signed
    coef_s = signed'({1'b0, coef});
    prod   = ACC_W'(coef_s) * ACC_W'(operand);
    acc_d  = acc_q;
    if (en) begin
      acc_d = load ? prod : acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/pid_increment.sv
// Velocity-form PID increment: d_uk = Kp*de + Ki*e + Kd*d2e over one shared MAC.
// Define PID_INC_SAT_FLAG_EN to add the sat flag (set when d_uk was clamped).
module pid_increment
  import pid_pkg::*;
#(
  parameter int unsigned ERR_W  = PID_ERR_W,
  parameter int unsigned COEF_W = PID_COEF_W,
  parameter int unsigned FRAC_W = PID_FRAC_W,
  parameter int unsigned DATA_W = PID_DATA_W
) (
  input logic             clk,
  input logic             rst_n,
  pid_increment_if.slave  bus
);

  localparam int unsigned E_W   = ERR_W + 1;
  localparam int unsigned D1_W  = ERR_W + 2;
  localparam int unsigned D2_W  = ERR_W + 3;
  localparam int unsigned ACC_W = COEF_W + ERR_W + 5;
  localparam logic signed [ACC_W-1:0] LIM_MAX = ACC_W'(pid_lim_max(DATA_W));
  localparam logic signed [ACC_W-1:0] LIM_MIN = ACC_W'(pid_lim_min(DATA_W));

  pid_state_e               state_q, state_d;
  logic signed [E_W-1:0]    e_q, e_d, e1_q, e1_d, e2_q, e2_d, e_new;
  logic        [COEF_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [DATA_W-1:0] d_uk_q, d_uk_d, clamped;
  logic                     out_valid_q, out_valid_d, clip;
  logic signed [D1_W-1:0]   diff1;
  logic signed [D2_W-1:0]   diff2;
  logic signed [ACC_W-1:0]  mac_acc, shifted;
  logic                     mac_en, mac_load;
  logic        [COEF_W-1:0] mac_coef;
  logic signed [D2_W-1:0]   mac_op;
`ifdef PID_INC_SAT_FLAG_EN
  logic                     sat_q, sat_d;
`endif

  pid_mac #(
    .COEF_W (COEF_W),
    .OP_W   (D2_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (mac_en),
    .load    (mac_load),
    .coef    (mac_coef),
    .operand (mac_op),
    .acc     (mac_acc)
  );

  always_comb begin
    e_new   = E_W'(bus.setpoint) - E_W'(bus.feedback);
    diff1   = D1_W'(e_q) - D1_W'(e1_q);
    diff2   = D2_W'(e_q) - (D2_W'(e1_q) <<< 1) + D2_W'(e2_q);
    shifted = mac_acc >>> FRAC_W;
    clip    = 1'b0;
    clamped = DATA_W'(shifted);
    if (shifted > LIM_MAX) begin
      clamped = DATA_W'(LIM_MAX);
      clip    = 1'b1;
    end else if (shifted < LIM_MIN) begin
      clamped = DATA_W'(LIM_MIN);
      clip    = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    e1_d        = e1_q;
    e2_d        = e2_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    kd_d        = kd_q;
    d_uk_d      = d_uk_q;
    out_valid_d = 1'b0;
    mac_en      = 1'b0;
    mac_load    = 1'b0;
    mac_coef    = '0;
    mac_op      = '0;
`ifdef PID_INC_SAT_FLAG_EN
    sat_d       = sat_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          e_d     = e_new;
          kp_d    = bus.kp;
          ki_d    = bus.ki;
          kd_d    = bus.kd;
          state_d = ST_MUL_P;
        end
      end
      ST_MUL_P: begin
        mac_en   = 1'b1;
        mac_load = 1'b1;
        mac_coef = kp_q;
        mac_op   = D2_W'(diff1);
        state_d  = ST_MUL_I;
      end
      ST_MUL_I: begin
        mac_en   = 1'b1;
        mac_coef = ki_q;
        mac_op   = D2_W'(e_q);
        state_d  = ST_MUL_D;
      end
      ST_MUL_D: begin
        mac_en   = 1'b1;
        mac_coef = kd_q;
        mac_op   = diff2;
        state_d  = ST_SAT;
      end
      ST_SAT: begin
        d_uk_d      = clamped;
        out_valid_d = 1'b1;
        e2_d        = e1_q;
        e1_d        = e_q;
`ifdef PID_INC_SAT_FLAG_EN
        sat_d       = clip;
`endif
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      e_q         <= '0;
      e1_q        <= '0;
      e2_q        <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      d_uk_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      d_uk_q      <= d_uk_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef PID_INC_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
  assign bus.sat = sat_q;
`else
  logic unused_clip;
  assign unused_clip = clip;
`endif

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.d_uk      = d_uk_q;

endmodule

// File: tb/tb_pid_increment.sv
// Directed and randomized bench for pid_increment against an arithmetic reference model.
module tb_pid_increment;

  localparam int ERR_W  = 12;
  localparam int COEF_W = 8;
  localparam int FRAC_W = 4;
  localparam int DATA_W = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pid_increment_if #(.ERR_W(ERR_W), .COEF_W(COEF_W), .DATA_W(DATA_W)) bus ();

  pid_increment #(
    .ERR_W  (ERR_W),
    .COEF_W (COEF_W),
    .FRAC_W (FRAC_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int m_e1  = 0;
  int m_e2  = 0;
  bit m_sat = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum, floor division by 2^FRAC_W, clamp to output range.
  function automatic int ref_duk(input int e, input int k_p, input int k_i, input int k_d);
    int acc, q, hi, lo;
    hi    = (1 << (DATA_W - 1)) - 1;
    lo    = -(1 << (DATA_W - 1));
    acc   = k_p * (e - m_e1) + k_i * e + k_d * (e - 2 * m_e1 + m_e2);
    q     = acc >>> FRAC_W;
    m_sat = (q > hi) || (q < lo);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    m_e1  = 0;
    m_e2  = 0;
  endtask

  task automatic drive(input int sp, input int fb, input int k_p, input int k_i, input int k_d);
    bus.setpoint = sp[ERR_W-1:0];
    bus.feedback = fb[ERR_W-1:0];
    bus.kp       = k_p[COEF_W-1:0];
    bus.ki       = k_i[COEF_W-1:0];
    bus.kd       = k_d[COEF_W-1:0];
  endtask

  task automatic run_sample(input string tag, input int sp, input int fb,
                            input int k_p, input int k_i, input int k_d);
    int n, lat, exp;
    @(negedge clk);
    drive(sp, fb, k_p, k_i, k_d);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, bus.in_ready, 1);
    if (bus.in_ready !== 1'b1) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    exp  = ref_duk(sp - fb, k_p, k_i, k_d);
    m_e2 = m_e1;
    m_e1 = sp - fb;
    check({tag, "_lat"}, lat, 4);
    check({tag, "_ovalid"}, bus.out_valid, 1);
    check({tag, "_duk"}, $signed(bus.d_uk), exp);
    check({tag, "_ready_back"}, bus.in_ready, 1);
`ifdef PID_INC_SAT_FLAG_EN
    check({tag, "_sat"}, bus.sat, int'(m_sat));
`endif
    @(negedge clk);
    check({tag, "_pulse"}, bus.out_valid, 0);
    check({tag, "_hold"}, $signed(bus.d_uk), exp);
  endtask

  initial begin
    int exp, sp, fb;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    drive(0, 0, 0, 0, 0);

    // reset state
    do_reset(3);
    check("rst_ready", bus.in_ready, 1);
    check("rst_ovalid", bus.out_valid, 0);
    check("rst_duk", $signed(bus.d_uk), 0);
`ifdef PID_INC_SAT_FLAG_EN
    check("rst_sat", bus.sat, 0);
`endif

    // proportional only: step then steady
    run_sample("p1", 100, 0, 16, 0, 0);
    run_sample("p2", 100, 0, 16, 0, 0);

    // integral only
    do_reset(2);
    for (int i = 0; i < 3; i++) run_sample("i", 10, 0, 0, 16, 0);

    // derivative only
    do_reset(2);
    for (int i = 0; i < 3; i++) run_sample("d", 10, 0, 0, 0, 16);

    // saturation in both directions
    do_reset(2);
    run_sample("sat_hi", 2047, -2048, 127, 0, 0);
    run_sample("sat_lo", -2048, 2047, 127, 0, 0);
    run_sample("sat_in", 100, 100, 0, 16, 0);

    // continuous in_valid: one accept every 5 cycles
    do_reset(2);
    @(negedge clk);
    drive(30, 0, 16, 0, 0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      check("held_ready", bus.in_ready, int'(i % 5 == 0));
      check("held_ovalid", bus.out_valid, int'(i > 0 && i % 5 == 0));
      if (i > 0 && i % 5 == 0) begin
        exp  = ref_duk(30, 16, 0, 0);
        m_e2 = m_e1;
        m_e1 = 30;
        check("held_duk", $signed(bus.d_uk), exp);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    // reset while the multiplier is mid-sequence
    do_reset(2);
    run_sample("pre_abort", 50, 0, 16, 0, 0);
    @(negedge clk);
    drive(70, 0, 16, 0, 0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ovalid", bus.out_valid, 0);
    check("abort_duk", $signed(bus.d_uk), 0);
    check("abort_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    m_e1  = 0;
    m_e2  = 0;
    for (int i = 0; i < 6; i++) begin
      check("abort_quiet", bus.out_valid, 0);
      @(negedge clk);
    end
    run_sample("post_abort", 20, 0, 16, 0, 0);

    // randomized samples and gains
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      sp = int'($urandom_range(4095)) - 2048;
      fb = int'($urandom_range(4095)) - 2048;
      if (i % 4 == 0) fb = sp - (int'($urandom_range(200)) - 100);
      run_sample("rand", sp, fb, int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
